adc_scan_scheduler: RTL and testbench

// Round-robin scheduler for the shared 8-channel serial ADC sampler. Drives the sampler's

---
 rtl/adc_scan_scheduler.sv | 164 ++++++++++++++++
 tb/tb_adc_scan_scheduler.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan_scheduler.sv
// Round-robin channel scheduler for the shared 8-channel serial ADC sampler.
// Discards settling frames after each switch and emits averaged, tagged samples.
module adc_scan_scheduler #(
  parameter int FRAME_CYCLES  = 15,
  parameter int SETTLE_FRAMES = 2,
  parameter int AVG_LOG2      = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [7:0]  chan_mask,
  input  logic [11:0] adc_result,
  output logic [2:0]  adc_chan,
  output logic        sample_valid,
  output logic [11:0] sample_data,
  output logic [2:0]  sample_chan,
  output logic        scan_done,
  output logic        busy
);

  localparam int FW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam int AW = 12 + AVG_LOG2;
  localparam int CW = 8;
  localparam logic [FW-1:0] FRAME_LAST  = FW'(FRAME_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_FRAMES - 1);
  localparam logic [CW-1:0] ACCUM_LAST  = CW'((1 << AVG_LOG2) - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    ACCUM,
    EMIT
  } state_t;

  state_t        state, state_d;
  logic [FW-1:0] frame_cnt;
  logic          frame_tick;
  logic [CW-1:0] cnt, cnt_d;
  logic [AW-1:0] acc, acc_d, acc_sum;
  logic [2:0]    chan_d, schan_d;
  logic [11:0]   data_d;
  logic [2:0]    first_chan, next_hi, next_chan;
  logic          wrap;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt <= '0;
    end else if (frame_cnt == FRAME_LAST) begin
      frame_cnt <= '0;
    end else begin
      frame_cnt <= frame_cnt + FW'(1);
    end
  end

  assign frame_tick = (frame_cnt == FRAME_LAST);
  assign acc_sum    = acc + AW'(adc_result);

  // Lowest set bit, and lowest set bit strictly above the current channel.
  always_comb begin
    first_chan = '0;
    next_hi    = '0;
    wrap       = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      if (chan_mask[i]) begin
        first_chan = 3'(i);
      end
      if (chan_mask[i] && (i > int'(adc_chan))) begin
        next_hi = 3'(i);
        wrap    = 1'b0;
      end
    end
    next_chan = wrap ? first_chan : next_hi;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    acc_d   = acc;
    chan_d  = adc_chan;
    data_d  = sample_data;
    schan_d = sample_chan;
    unique case (state)
      IDLE: begin
        if (frame_tick && enable && (|chan_mask)) begin
          chan_d  = first_chan;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (frame_tick) begin
          if (cnt == SETTLE_LAST) begin
            cnt_d   = '0;
            state_d = ACCUM;
          end else begin
            cnt_d = cnt + CW'(1);
          end
        end
      end
      ACCUM: begin
        if (frame_tick) begin
          acc_d = acc_sum;
          if (cnt == ACCUM_LAST) begin
            data_d  = acc_sum[AW-1:AVG_LOG2];
            schan_d = adc_chan;
            state_d = EMIT;
          end else begin
            cnt_d = cnt + CW'(1);
          end
        end
      end
      EMIT: begin
        if (|chan_mask) begin
          chan_d  = next_chan;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = SETTLE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort wins over everything; an EMIT pulse already showing still completes.
    if ((state != IDLE) && !enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      acc_d   = '0;
      chan_d  = adc_chan;
      data_d  = sample_data;
      schan_d = sample_chan;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt         <= '0;
      acc         <= '0;
      adc_chan    <= '0;
      sample_data <= '0;
      sample_chan <= '0;
    end else begin
      cnt         <= cnt_d;
      acc         <= acc_d;
      adc_chan    <= chan_d;
      sample_data <= data_d;
      sample_chan <= schan_d;
    end
  end

  assign sample_valid = (state == EMIT);
  assign scan_done    = (state == EMIT) && (|chan_mask) && wrap;
  assign busy         = (state != IDLE);

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Randomized scoreboard bench for adc_scan_scheduler.
// A frame-level reference model predicts every tagged sample and its cycle.
module tb_adc_scan_scheduler;

  localparam int F = 15;
  localparam int S = 2;
  localparam int A = 2;
  localparam int N = 1 << A;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [7:0]  chan_mask;
  logic [11:0] adc_result;
  logic [2:0]  adc_chan;
  logic        sample_valid;
  logic [11:0] sample_data;
  logic [2:0]  sample_chan;
  logic        scan_done;
  logic        busy;

  adc_scan_scheduler #(
    .FRAME_CYCLES (F),
    .SETTLE_FRAMES(S),
    .AVG_LOG2     (A)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .chan_mask   (chan_mask),
    .adc_result  (adc_result),
    .adc_chan    (adc_chan),
    .sample_valid(sample_valid),
    .sample_data (sample_data),
    .sample_chan (sample_chan),
    .scan_done   (scan_done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int chan;
    int data;
    int done;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // reference model state
  int fp = 0;
  int cyc = 0;
  int k = 0;
  int sum = 0;
  int m_chan = 0;
  bit active = 0;
  bit emit_pend = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int lowest(input logic [7:0] m);
    for (int i = 0; i < 8; i++) if (m[i]) return i;
    return -1;
  endfunction

  function automatic int above(input logic [7:0] m, input int c);
    for (int i = c + 1; i < 8; i++) if (m[i]) return i;
    return -1;
  endfunction

  // Frame-level model: a pass selects a channel, skips S frames,
  // averages the next N frame results, then moves to the next mask bit.
  initial begin
    bit   tick;
    int   nxt;
    exp_t e;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        fp = 0;
        active = 0;
        emit_pend = 0;
        k = 0;
        sum = 0;
        q.delete();
      end else begin
        cyc++;
        emit_pend = 0;
        tick = (fp == F - 1);
        fp = (fp + 1) % F;
        if (active && !enable) begin
          active = 0;
        end else if (tick) begin
          if (!active) begin
            if (enable && chan_mask != 0) begin
              active = 1;
              m_chan = lowest(chan_mask);
              k = 0;
              sum = 0;
            end
          end else begin
            k++;
            if (k > S) sum += adc_result;
            if (k == S + N) begin
              nxt = above(chan_mask, m_chan);
              e.cyc = cyc;
              e.chan = m_chan;
              e.data = sum / N;
              e.done = (chan_mask != 0 && nxt < 0) ? 1 : 0;
              q.push_back(e);
              emit_pend = 1;
              if (chan_mask == 0) begin
                active = 0;
              end else begin
                m_chan = (nxt < 0) ? lowest(chan_mask) : nxt;
                k = 0;
                sum = 0;
              end
            end
          end
        end
      end
    end
  end

  // Monitor: compares whatever the DUT presents against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        check("busy", busy, int'(active || emit_pend));
        while (q.size() > 0 && q[0].cyc < cyc) begin
          e = q.pop_front();
          check("missed_sample_cycle", cyc, e.cyc);
        end
        if (sample_valid) begin
          if (q.size() == 0) begin
            check("unexpected_valid", 1, 0);
          end else begin
            e = q.pop_front();
            check("sample_cycle", cyc, e.cyc);
            check("sample_chan", sample_chan, e.chan);
            check("sample_data", sample_data, e.data);
            check("scan_done", scan_done, e.done);
          end
        end else begin
          check("scan_done_idle", scan_done, 0);
        end
      end
    end
  end

  // Result bus: random, biased toward full scale to exercise the accumulator top.
  initial begin
    forever begin
      @(negedge clk);
      adc_result = ($urandom_range(3) == 0) ? 12'hFFF : 12'($urandom);
    end
  end

  task automatic run_frames(input int n);
    repeat (n * F) @(negedge clk);
  endtask

  // Wait for mid-frame so mask/enable are stable at every tick and EMIT.
  task automatic mid_frame();
    @(negedge clk);
    for (int i = 0; i < 2 * F && fp != 7; i++) @(negedge clk);
    if (fp != 7) check("mid_frame_timeout", fp, 7);
  endtask

  task automatic set_mask(input logic [7:0] m);
    mid_frame();
    chan_mask = m;
  endtask

  task automatic set_enable(input logic en);
    mid_frame();
    enable = en;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_adc_chan"}, adc_chan, 0);
    check({tag, "_sample_valid"}, sample_valid, 0);
    check({tag, "_sample_data"}, sample_data, 0);
    check({tag, "_sample_chan"}, sample_chan, 0);
    check({tag, "_scan_done"}, scan_done, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int lim;
    reset_n = 1'b0;
    enable = 1'b0;
    chan_mask = 8'h00;
    adc_result = 12'h000;
    repeat (3) @(negedge clk);
    #1;
    check_zero_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;
    enable = 1'b1;
    chan_mask = 8'h01;
    run_frames(20);

    set_mask(8'b1010_0100);
    run_frames(40);

    set_mask(8'h01);
    run_frames(8);
    set_mask(8'h80);
    run_frames(14);
    set_mask(8'h00);
    run_frames(10);

    set_mask(8'h08);
    lim = 0;
    while (!(active && k >= S && fp == 7) && lim < 300) begin
      @(negedge clk);
      lim++;
    end
    check("accum_wait_timeout", int'(lim < 300), 1);
    enable = 1'b0;
    run_frames(3);
    set_mask(8'h48);
    set_enable(1'b1);
    run_frames(16);

    repeat (14) begin
      if ($urandom_range(4) == 0) set_mask(8'h00);
      else set_mask(8'($urandom_range(255, 1)));
      if ($urandom_range(3) == 0) begin
        set_enable(1'b0);
        run_frames($urandom_range(2));
        set_enable(1'b1);
      end
      run_frames($urandom_range(12, 3));
    end

    set_mask(8'h3C);
    lim = 0;
    while (!(active && k < S) && lim < 300) begin
      @(negedge clk);
      lim++;
    end
    check("settle_wait_timeout", int'(lim < 300), 1);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    run_frames(20);

    check("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
